// File: rtl/mult_sign_pipe_pkg.sv
// Fixed-point helpers shared by the Goertzel datapath blocks:
// rounding mode, Q-format shift math and the saturating clamp.
package gz_fixp_pkg;

   localparam int SAT_MAXW = 64;

   typedef enum logic {
      RND_TRUNC   = 1'b0,
      RND_HALF_UP = 1'b1
   } rnd_mode_e;

   typedef struct packed {
      logic                ovf;
      logic [SAT_MAXW-1:0] val;
   } sat_t;

   function automatic int frq_f(input int dw, input int int_b);
      return dw - int_b;
   endfunction

   function automatic int sh_f(input int dw, input int i1,
                               input int i2, input int i3);
      return frq_f(dw, i1) + frq_f(dw, i2) - frq_f(dw, i3);
   endfunction

   // Clamp a sign-extended value into a signed field of 'width' bits.
   function automatic sat_t sat_s(input logic signed [SAT_MAXW-1:0] value,
                                  input int width);
      logic signed [SAT_MAXW-1:0] hi;
      logic signed [SAT_MAXW-1:0] lo;
      sat_t r;
      hi = $signed((SAT_MAXW'(1) << (width - 1)) - SAT_MAXW'(1));
      lo = ~hi;
      r.ovf = (value > hi) || (value < lo);
      if (value > hi)
         r.val = hi;
      else if (value < lo)
         r.val = lo;
      else
         r.val = value;
      return r;
   endfunction

endpackage

// File: rtl/mult_sign_pipe_if.sv
// Operand/result stream bundle of the fixed-point multiplier.
// Signal names are seen from the multiplier side.
interface mult_sign_pipe_if #(
   parameter int DW    = 16,
   parameter int TAG_W = 4
);
   logic [DW-1:0]    a_in;
   logic [DW-1:0]    b_in;
   logic [TAG_W-1:0] tag_in;
   logic             vld_in;
   logic             rdy_out;
   logic [DW-1:0]    c_out;
   logic [2*DW-1:0]  c_ful_out;
   logic [TAG_W-1:0] tag_out;
   logic             ovf_out;
   logic             vld_out;
   logic             rdy_in;

   modport master (
      output a_in, b_in, tag_in, vld_in, rdy_in,
      input  rdy_out, c_out, c_ful_out, tag_out, ovf_out, vld_out
   );

   modport slave (
      input  a_in, b_in, tag_in, vld_in, rdy_in,
      output rdy_out, c_out, c_ful_out, tag_out, ovf_out, vld_out
   );
endinterface

// File: rtl/mult_sign_pipe_fixp_round_sat.sv
// Combinational round + saturate of a full-width signed product
// down to a DW-bit result; also used by the accumulator.
module fixp_round_sat
   import gz_fixp_pkg::*;
#(
   parameter int DW       = 16,
   parameter int SH       = 15,
   parameter int RND_MODE = 1,
   parameter int SAT_EN   = 1
) (
   input  logic signed [2*DW-1:0] p_i,
   output logic [DW-1:0]          c_o,
   output logic                   ovf_o
);
   localparam int PW = 2*DW + 1;
   localparam bit DO_RND = (RND_MODE == int'(RND_HALF_UP)) && (SH > 0);
   localparam int HSH = (SH > 0) ? SH - 1 : 0;
   localparam logic signed [PW-1:0] HALF =
      DO_RND ? (PW'(1) << HSH) : PW'(0);

   logic signed [PW-1:0]       r_d;
   logic                       s_ovf;
   logic [SAT_MAXW-DW-1:0]     sat_unused;
   logic [DW-1:0]              c_sat;

   // One guard bit above the product so the half-LSB add cannot wrap.
   always_comb begin
      r_d = (PW'(p_i) + HALF) >>> SH;
      {s_ovf, sat_unused, c_sat} = sat_s(SAT_MAXW'(r_d), DW);
      ovf_o = s_ovf;
      c_o   = (SAT_EN != 0) ? c_sat : r_d[DW-1:0];
   end

endmodule

// File: rtl/mult_sign_pipe.sv
// Pipelined signed fixed-point multiplier, stall-all handshake,
// round/saturate into the output register, tag sideband.
module mult_sign_pipe
   import gz_fixp_pkg::*;
#(
   parameter int DW       = 16,
   parameter int INT1_I   = 1,
   parameter int INT2_I   = 1,
   parameter int INT3_O   = 1,
   parameter int LAT      = 3,
   parameter int RND_MODE = 1,
   parameter int SAT_EN   = 1,
   parameter int TAG_W    = 4
) (
   input  logic           clk_in,
   input  logic           rst_in,
   mult_sign_pipe_if.slave io
);
   localparam int SH  = sh_f(DW, INT1_I, INT2_I, INT3_O);
   localparam int PW2 = 2*DW;
   localparam int NP  = (LAT > 2) ? LAT - 2 : 1;

   if (SH < 0 || INT3_O < 1 || INT3_O > DW) begin : g_bad_fmt
      $error("mult_sign_pipe: illegal Q format");
   end
   if (LAT < 1 || LAT > 6) begin : g_bad_lat
      $error("mult_sign_pipe: LAT out of range");
   end
   if (DW > 31) begin : g_bad_dw
      $error("mult_sign_pipe: DW too wide");
   end

   logic                   adv;
   logic signed [DW-1:0]   a_s, b_s;
   logic [TAG_W-1:0]       t_s, pt_s;
   logic                   v_s, pv_s;
   logic signed [PW2-1:0]  p_d, p_s;
   logic [DW-1:0]          c_d;
   logic                   ovf_d;
   logic [DW-1:0]          c_q;
   logic [PW2-1:0]         cf_q;
   logic [TAG_W-1:0]       t_q;
   logic                   ovf_q, v_q;

   assign adv        = ~v_q | io.rdy_in;
   assign io.rdy_out = adv;

   if (LAT >= 2) begin : g_in
      logic [DW-1:0]    a_q, b_q;
      logic [TAG_W-1:0] t_in_q;
      logic             v_in_q;
      always_ff @(posedge clk_in or posedge rst_in) begin
         if (rst_in) begin
            a_q    <= '0;
            b_q    <= '0;
            t_in_q <= '0;
            v_in_q <= 1'b0;
         end else if (adv) begin
            a_q    <= io.a_in;
            b_q    <= io.b_in;
            t_in_q <= io.tag_in;
            v_in_q <= io.vld_in;
         end
      end
      assign a_s = a_q;
      assign b_s = b_q;
      assign t_s = t_in_q;
      assign v_s = v_in_q;
   end else begin : g_in_byp
      assign a_s = io.a_in;
      assign b_s = io.b_in;
      assign t_s = io.tag_in;
      assign v_s = io.vld_in;
   end

   assign p_d = PW2'(a_s) * PW2'(b_s);

   // Product register followed by LAT-3 plain delay slots.
   if (LAT >= 3) begin : g_prod
      logic [PW2-1:0]   p_q [NP];
      logic [TAG_W-1:0] t_p_q [NP];
      logic [NP-1:0]    v_p_q;
      always_ff @(posedge clk_in or posedge rst_in) begin
         if (rst_in) begin
            for (int i = 0; i < NP; i++) begin
               p_q[i]   <= '0;
               t_p_q[i] <= '0;
            end
            v_p_q <= '0;
         end else if (adv) begin
            p_q[0]   <= p_d;
            t_p_q[0] <= t_s;
            v_p_q[0] <= v_s;
            for (int i = 1; i < NP; i++) begin
               p_q[i]   <= p_q[i-1];
               t_p_q[i] <= t_p_q[i-1];
               v_p_q[i] <= v_p_q[i-1];
            end
         end
      end
      assign p_s  = p_q[NP-1];
      assign pt_s = t_p_q[NP-1];
      assign pv_s = v_p_q[NP-1];
   end else begin : g_prod_byp
      assign p_s  = p_d;
      assign pt_s = t_s;
      assign pv_s = v_s;
   end

   fixp_round_sat #(
      .DW       (DW),
      .SH       (SH),
      .RND_MODE (RND_MODE),
      .SAT_EN   (SAT_EN)
   ) u_rs (
      .p_i   (p_s),
      .c_o   (c_d),
      .ovf_o (ovf_d)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         v_q   <= 1'b0;
         c_q   <= '0;
         cf_q  <= '0;
         t_q   <= '0;
         ovf_q <= 1'b0;
      end else if (adv) begin
         v_q   <= pv_s;
         c_q   <= c_d;
         cf_q  <= p_s;
         t_q   <= pt_s;
         ovf_q <= ovf_d;
      end
   end

   assign io.vld_out   = v_q;
   assign io.c_out     = c_q;
   assign io.c_ful_out = cf_q;
   assign io.tag_out   = t_q;
   assign io.ovf_out   = ovf_q;

endmodule

// File: tb/tb_mult_sign_pipe.sv
// Bench for mult_sign_pipe: directed Q1.15 cases on one instance,
// randomized streams over every LAT/rounding/saturation combination.
module tb_mult_sign_pipe;

   typedef struct {
      logic [15:0] c;
      logic [31:0] cf;
      logic        ovf;
      logic [3:0]  tag;
   } exp_t;

   localparam int N_RAND = 150;
   localparam int N_CFG  = 24;
   localparam int TB_SH  = 15;

   logic clk   = 1'b0;
   logic rst_m = 1'b1;
   logic rst_g = 1'b1;
   int   n_chk  = 0;
   int   n_err  = 0;
   int   n_done = 0;

   logic [15:0] dir_a [4] = '{16'h4000, 16'h0001, 16'hFFFF, 16'h8000};
   logic [15:0] dir_b [4] = '{16'h4000, 16'h4000, 16'h4000, 16'h8000};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   // Q1.15 x Q1.15 -> Q1.15 from the arithmetic definition.
   function automatic exp_t ref_mul(input logic [15:0] a, input logic [15:0] b,
                                    input logic [3:0] tg, input int rnd,
                                    input int sat);
      exp_t   e;
      longint p;
      longint r;
      p = longint'($signed(a)) * longint'($signed(b));
      r = (rnd != 0) ? p + (longint'(1) <<< (TB_SH - 1)) : p;
      r = r >>> TB_SH;
      e.ovf = (r > 32767) || (r < -32768);
      if (sat != 0 && r > 32767)
         e.c = 16'h7FFF;
      else if (sat != 0 && r < -32768)
         e.c = 16'h8000;
      else
         e.c = 16'(r);
      e.cf  = 32'(p);
      e.tag = tg;
      return e;
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(7))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   mult_sign_pipe_if #(.DW(16), .TAG_W(4)) mio ();

   mult_sign_pipe #(
      .DW(16), .INT1_I(1), .INT2_I(1), .INT3_O(1),
      .LAT(3), .RND_MODE(1), .SAT_EN(1), .TAG_W(4)
   ) dut (
      .clk_in (clk),
      .rst_in (rst_m),
      .io     (mio)
   );

   for (genvar L = 1; L <= 6; L++) begin : g_lat
      for (genvar M = 0; M < 4; M++) begin : g_mode
         localparam int RND = M % 2;
         localparam int SAT = M / 2;

         mult_sign_pipe_if #(.DW(16), .TAG_W(4)) rio ();

         mult_sign_pipe #(
            .DW(16), .INT1_I(1), .INT2_I(1), .INT3_O(1),
            .LAT(L), .RND_MODE(RND), .SAT_EN(SAT), .TAG_W(4)
         ) u_dut (
            .clk_in (clk),
            .rst_in (rst_g),
            .io     (rio)
         );

         exp_t        sb[$];
         exp_t        e;
         int          sent, got, cyc;
         logic [15:0] ra, rb;
         string       pfx;

         initial begin
            pfx = $sformatf("L%0d_R%0d_S%0d", L, RND, SAT);
            rio.a_in = '0; rio.b_in = '0; rio.tag_in = '0;
            rio.vld_in = 1'b0; rio.rdy_in = 1'b0;
            sent = 0; got = 0; cyc = 0;
            while (rst_g) @(negedge clk);
            while (got < N_RAND && cyc < 5000) begin
               @(negedge clk);
               cyc++;
               if (sent < 4) begin
                  ra = dir_a[sent];
                  rb = dir_b[sent];
               end else begin
                  ra = pick();
                  rb = pick();
               end
               rio.a_in   = ra;
               rio.b_in   = rb;
               rio.tag_in = 4'(sent);
               rio.vld_in = (sent < N_RAND) && ($urandom_range(3) != 0);
               rio.rdy_in = ($urandom_range(9) < 7);
               #1;
               if (rio.vld_out) begin
                  if (sb.size() == 0) begin
                     chk({pfx, "_spurious"}, 1, 0);
                  end else begin
                     e = sb[0];
                     chk({pfx, "_c"}, rio.c_out, e.c);
                     chk({pfx, "_cf"}, rio.c_ful_out, e.cf);
                     chk({pfx, "_ovf"}, rio.ovf_out, e.ovf);
                     chk({pfx, "_tag"}, rio.tag_out, e.tag);
                     if (rio.rdy_in) begin
                        case (got)
                           0: chk({pfx, "_d0"}, rio.c_out, 16'h2000);
                           1: chk({pfx, "_d1"}, rio.c_out,
                                  (RND != 0) ? 16'h0001 : 16'h0000);
                           2: chk({pfx, "_d2"}, rio.c_out,
                                  (RND != 0) ? 16'h0000 : 16'hFFFF);
                           3: begin
                              chk({pfx, "_d3"}, rio.c_out,
                                  (SAT != 0) ? 16'h7FFF : 16'h8000);
                              chk({pfx, "_d3ovf"}, rio.ovf_out, 1);
                              chk({pfx, "_d3cf"}, rio.c_ful_out, 32'h40000000);
                           end
                           default: ;
                        endcase
                        void'(sb.pop_front());
                        got++;
                     end
                  end
               end
               if (rio.vld_in && rio.rdy_out) begin
                  sb.push_back(ref_mul(ra, rb, 4'(sent), RND, SAT));
                  sent++;
               end
            end
            chk({pfx, "_count"}, got, N_RAND);
            n_done++;
         end
      end
   end

   task automatic one_shot(input string nm, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] tg,
                           input logic [15:0] ec, input logic [31:0] ecf,
                           input logic eo);
      int lat;
      @(negedge clk);
      mio.a_in = a; mio.b_in = b; mio.tag_in = tg;
      mio.vld_in = 1'b1; mio.rdy_in = 1'b1;
      #1 chk({nm, "_rdy"}, mio.rdy_out, 1);
      lat = 0;
      do begin
         @(negedge clk);
         mio.vld_in = 1'b0;
         lat++;
         #1;
      end while (!mio.vld_out && lat < 10);
      chk({nm, "_lat"}, lat, 3);
      chk({nm, "_c"}, mio.c_out, ec);
      chk({nm, "_cf"}, mio.c_ful_out, ecf);
      chk({nm, "_tag"}, mio.tag_out, tg);
      chk({nm, "_ovf"}, mio.ovf_out, eo);
   endtask

   exp_t        msb[$];
   exp_t        me;
   int          nacc, ngot;
   logic [15:0] ta, tbv;

   initial begin
      mio.a_in = '0; mio.b_in = '0; mio.tag_in = '0;
      mio.vld_in = 1'b0; mio.rdy_in = 1'b0;
      #3;
      chk("rst_vld", mio.vld_out, 0);
      chk("rst_c", mio.c_out, 0);
      chk("rst_cf", mio.c_ful_out, 0);
      chk("rst_tag", mio.tag_out, 0);
      chk("rst_ovf", mio.ovf_out, 0);
      chk("rst_rdy", mio.rdy_out, 1);
      @(negedge clk);
      @(negedge clk);
      rst_m = 1'b0;
      rst_g = 1'b0;

      one_shot("t1", 16'h4000, 16'h4000, 4'd5, 16'h2000, 32'h10000000, 1'b0);
      one_shot("t2a", 16'h0001, 16'h4000, 4'd1, 16'h0001, 32'h00004000, 1'b0);
      one_shot("t2b", 16'hFFFF, 16'h4000, 4'd2, 16'h0000, 32'hFFFFC000, 1'b0);
      one_shot("t3", 16'h8000, 16'h8000, 4'd3, 16'h7FFF, 32'h40000000, 1'b1);
      @(negedge clk);

      // Stall with rdy_in low, then release and drain in order.
      nacc = 0;
      ngot = 0;
      for (int cyc = 0; cyc < 40 && ngot < 5; cyc++) begin
         @(negedge clk);
         ta  = 16'(16'h0C00 * (nacc + 1));
         tbv = 16'hA000;
         mio.a_in   = ta;
         mio.b_in   = tbv;
         mio.tag_in = 4'(nacc);
         mio.vld_in = (nacc < 5);
         mio.rdy_in = (cyc >= 8);
         #1;
         if (cyc == 7) begin
            chk("t4_acc", nacc, 3);
            chk("t4_rdy", mio.rdy_out, 0);
         end
         if (mio.vld_out) begin
            if (msb.size() == 0) begin
               chk("t4_spurious", 1, 0);
            end else begin
               me = msb[0];
               chk("t4_c", mio.c_out, me.c);
               chk("t4_tag", mio.tag_out, me.tag);
               chk("t4_ovf", mio.ovf_out, me.ovf);
               if (mio.rdy_in) begin
                  void'(msb.pop_front());
                  ngot++;
               end
            end
         end
         if (mio.vld_in && mio.rdy_out) begin
            msb.push_back(ref_mul(ta, tbv, 4'(nacc), 1, 1));
            nacc++;
         end
      end
      chk("t4_cnt", ngot, 5);
      mio.vld_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 chk("t4_dup", mio.vld_out, 0);
      end

      // Reset with two items in flight.
      mio.rdy_in = 1'b0;
      nacc = 0;
      for (int cyc = 0; cyc < 6 && nacc < 2; cyc++) begin
         @(negedge clk);
         mio.a_in = 16'h3000; mio.b_in = 16'h3000;
         mio.tag_in = 4'(6 + nacc); mio.vld_in = 1'b1;
         #1;
         if (mio.rdy_out) nacc++;
      end
      @(negedge clk);
      mio.vld_in = 1'b0;
      #1;
      for (int cyc = 0; cyc < 6 && !mio.vld_out; cyc++) begin
         @(negedge clk);
         #1;
      end
      chk("t5_pre_vld", mio.vld_out, 1);
      chk("t5_pre_tag", mio.tag_out, 6);
      #2 rst_m = 1'b1;
      #1;
      chk("t5_async_vld", mio.vld_out, 0);
      chk("t5_async_c", mio.c_out, 0);
      chk("t5_async_rdy", mio.rdy_out, 1);
      @(negedge clk);
      @(negedge clk);
      rst_m = 1'b0;
      mio.rdy_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 chk("t5_stale", mio.vld_out, 0);
      end
      one_shot("t5", 16'h2000, 16'h2000, 4'd9, 16'h0800, 32'h04000000, 1'b0);

      for (int i = 0; i < 20000 && n_done < N_CFG; i++) @(negedge clk);
      chk("rand_done", n_done, N_CFG);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
